// File: rtl/if_id_fetch_if.sv
// Instruction-memory read bus between the fetch stage and instruction memory.
// Ports (master = fetch stage):
//   imemReq   - read request, held until imemReady
//   imemAddr  - word-aligned read address, stable while waiting
//   imemReady - read completes this cycle
//   imemData  - instruction word, valid with imemReady
interface if_id_fetch_if;
    localparam int unsigned XLEN = 32;

    logic            imemReq;
    logic [XLEN-1:0] imemAddr;
    logic            imemReady;
    logic [XLEN-1:0] imemData;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemReady,
        input  imemData
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemReady,
        output imemData
    );
endinterface

// File: rtl/if_id_fetch.sv
// MIPS32 instruction-fetch stage with the IF/ID pipeline register.
// Owns the PC, reads instruction memory over a req/ready handshake and hands
// {instruction, PC+4, valid} to ID. Holds on load-use stalls, redirects on
// taken branches and squashes a read that is in flight when a redirect lands.
// Ports:
//   Clock, Reset  - clock and synchronous active-high reset
//   pcWrite       - 0 = load-use stall (PC and IF/ID hold)
//   branchTaken   - redirect request from ID
//   branchTarget  - redirect address (low two bits ignored)
//   imem          - instruction-memory read bus (master side)
//   pc            - current fetch PC
//   instrID       - IF/ID instruction
//   pcPlus4ID     - IF/ID PC+4
//   validID       - IF/ID holds a real instruction
module if_id_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 pcWrite,
    input  logic                 branchTaken,
    input  logic [31:0]          branchTarget,
    if_id_fetch_if.master        imem,
    output logic [31:0]          pc,
    output logic [31:0]          instrID,
    output logic [31:0]          pcPlus4ID,
    output logic                 validID
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } stateT;

    stateT           state;
    logic [XLEN-1:0] holdBuf;
    logic [XLEN-1:0] squashAddr;
    logic [XLEN-1:0] pcPlus4;
    logic [XLEN-1:0] targetAligned;

    assign pcPlus4       = pc + XLEN'(4);
    assign targetAligned = {branchTarget[XLEN-1:2], 2'b00};

    // Request is decoded from registered state so the first request appears
    // in the first cycle out of reset; a squashed read keeps its own address.
    assign imem.imemReq  = !Reset && (state != HOLD);
    assign imem.imemAddr = (state == DISCARD) ? squashAddr : pc;

    // Fetch FSM, PC and IF/ID register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            instrID    <= NOP;
            pcPlus4ID  <= '0;
            validID    <= 1'b0;
            holdBuf    <= '0;
            squashAddr <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (branchTaken) begin
                        pc        <= targetAligned;
                        instrID   <= NOP;
                        pcPlus4ID <= '0;
                        validID   <= 1'b0;
                        // Read still outstanding: remember its address so the
                        // bus stays stable, and drop its data when it lands.
                        if (!imem.imemReady) begin
                            squashAddr <= pc;
                            state      <= DISCARD;
                        end
                    end else if (imem.imemReady) begin
                        if (pcWrite) begin
                            instrID   <= imem.imemData;
                            pcPlus4ID <= pcPlus4;
                            validID   <= 1'b1;
                            pc        <= pcPlus4;
                        end else begin
                            // Park the word so release needs no refetch.
                            holdBuf <= imem.imemData;
                            state   <= HOLD;
                        end
                    end else if (pcWrite) begin
                        instrID   <= NOP;
                        pcPlus4ID <= '0;
                        validID   <= 1'b0;
                    end
                end
                HOLD: begin
                    if (branchTaken) begin
                        pc        <= targetAligned;
                        instrID   <= NOP;
                        pcPlus4ID <= '0;
                        validID   <= 1'b0;
                        state     <= FETCH;
                    end else if (pcWrite) begin
                        instrID   <= holdBuf;
                        pcPlus4ID <= pcPlus4;
                        validID   <= 1'b1;
                        pc        <= pcPlus4;
                        state     <= FETCH;
                    end
                end
                DISCARD: begin
                    if (branchTaken) begin
                        pc <= targetAligned;
                    end
                    if (imem.imemReady) begin
                        state <= FETCH;
                    end
                    if (pcWrite) begin
                        instrID   <= NOP;
                        pcPlus4ID <= '0;
                        validID   <= 1'b0;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_if_id_fetch.sv
// Randomized scoreboard bench for if_id_fetch.
// The stimulus process drives one cycle at a time, advances a behavioural
// model of the fetch stage and queues the expected bus request and the
// expected post-edge PC / IF/ID contents. A separate monitor pops and compares.
module tb_if_id_fetch;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] NOPW   = 32'h0000_0000;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] p4;
        logic        valid;
    } expT;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        pcWrite = 1'b1;
    logic        branchTaken = 1'b0;
    logic [31:0] branchTarget = '0;
    logic [31:0] pc;
    logic [31:0] instrID;
    logic [31:0] pcPlus4ID;
    logic        validID;

    if_id_fetch_if bus ();

    if_id_fetch #(.RESET_PC(RST_PC), .NOP(NOPW)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .pcWrite     (pcWrite),
        .branchTaken (branchTaken),
        .branchTarget(branchTarget),
        .imem        (bus),
        .pc          (pc),
        .instrID     (instrID),
        .pcPlus4ID   (pcPlus4ID),
        .validID     (validID)
    );

    // Memory: every word is its address xor a key.
    assign bus.imemData = bus.imemAddr ^ KEY;
    initial bus.imemReady = 1'b0;

    always #5 Clock = ~Clock;

    int  nChecks = 0;
    int  nFails  = 0;
    expT expQ[$];

    // Reference model: PC, an outstanding read to be thrown away, a word
    // parked during a stall, and the ID-side tuple.
    logic [31:0] mPc = RST_PC;
    logic        mSquash = 1'b0;
    logic [31:0] mSquashAddr = '0;
    logic        mHeld = 1'b0;
    logic [31:0] mHeldWord = '0;
    logic [31:0] mInstr = NOPW;
    logic [31:0] mP4 = '0;
    logic        mValid = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic bubble();
        mInstr = NOPW;
        mP4    = '0;
        mValid = 1'b0;
    endtask

    task automatic step(input logic rst, input logic pw, input logic bt,
                        input logic [31:0] tgt, input logic rdyIn);
        expT         e;
        logic        rdy;
        logic [31:0] tgtA;
        @(negedge Clock);
        e.req  = !rst && !mHeld;
        e.addr = mSquash ? mSquashAddr : mPc;
        // Memory only answers real requests, except for a late answer during reset.
        rdy    = rst ? rdyIn : (rdyIn && e.req);
        tgtA   = tgt & 32'hFFFF_FFFC;
        Reset         = rst;
        pcWrite       = pw;
        branchTaken   = bt;
        branchTarget  = tgt;
        bus.imemReady = rdy;
        if (rst) begin
            mPc = RST_PC; mSquash = 1'b0; mHeld = 1'b0;
            bubble();
        end else if (mHeld) begin
            if (bt) begin
                mPc = tgtA; mHeld = 1'b0; bubble();
            end else if (pw) begin
                mInstr = mHeldWord; mP4 = mPc + 32'd4; mValid = 1'b1;
                mPc = mPc + 32'd4; mHeld = 1'b0;
            end
        end else if (mSquash) begin
            if (bt) mPc = tgtA;
            if (rdy) mSquash = 1'b0;
            if (pw) bubble();
        end else begin
            if (bt) begin
                if (!rdy) begin
                    mSquash = 1'b1; mSquashAddr = mPc;
                end
                mPc = tgtA; bubble();
            end else if (rdy && pw) begin
                mInstr = mPc ^ KEY; mP4 = mPc + 32'd4; mValid = 1'b1;
                mPc = mPc + 32'd4;
            end else if (rdy) begin
                mHeld = 1'b1; mHeldWord = mPc ^ KEY;
            end else if (pw) begin
                bubble();
            end
        end
        e.pc = mPc; e.instr = mInstr; e.p4 = mP4; e.valid = mValid;
        expQ.push_back(e);
    endtask

    // Monitor: request is sampled before the edge, state after it.
    initial begin
        expT         e;
        logic        gotReq;
        logic [31:0] gotAddr;
        forever begin
            @(negedge Clock);
            #2;
            if (expQ.size() == 0) continue;
            gotReq  = bus.imemReq;
            gotAddr = bus.imemAddr;
            @(posedge Clock);
            #1;
            e = expQ.pop_front();
            check("imemReq", 32'(gotReq), 32'(e.req));
            if (e.req) check("imemAddr", gotAddr, e.addr);
            check("pc", pc, e.pc);
            check("validID", 32'(validID), 32'(e.valid));
            check("instrID", instrID, e.instr);
            if (e.valid) check("pcPlus4ID", pcPlus4ID, e.p4);
        end
    end

    initial begin
        logic        rRst;
        logic        rPw;
        logic        rBt;
        logic        rRdy;
        logic [31:0] rTgt;
        // Reset, then stream across the 32-bit wrap.
        step(1, 1, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        repeat (4) step(0, 1, 0, 0, 1);
        // Zero-wait stream from 0x400.
        step(0, 1, 1, 32'h400, 1);
        repeat (5) step(0, 1, 0, 0, 1);
        // Load-use stall at 0x10 for two cycles, then release.
        step(0, 1, 1, 32'h10, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        repeat (2) step(0, 1, 0, 0, 1);
        // Zero-wait branch from 0x20 to 0x80.
        step(0, 1, 1, 32'h20, 1);
        step(0, 1, 1, 32'h80, 1);
        repeat (2) step(0, 1, 0, 0, 1);
        // Branch to 0x200 while a read waits three cycles.
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 32'h200, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        repeat (2) step(0, 1, 0, 0, 1);
        // Stall and branch together: redirect wins.
        step(0, 0, 1, 32'h300, 1);
        step(0, 1, 0, 0, 1);
        // Misaligned target.
        step(0, 1, 1, 32'h0000_1237, 1);
        step(0, 1, 0, 0, 1);
        // Reset during a stall, and during a squashed read with a late ready.
        step(0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(0, 1, 1, 32'h500, 0);
        step(1, 1, 0, 0, 1);
        repeat (2) step(0, 1, 0, 0, 1);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rRst = ($urandom_range(99) == 0);
            rPw  = ($urandom_range(3) != 0);
            rBt  = ($urandom_range(7) == 0);
            rRdy = ($urandom_range(2) != 0);
            rTgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            step(rRst, rPw, rBt, rTgt, rRdy);
        end
        @(posedge Clock);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
